instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the control unit and datapath: holds the PC, requests instructions

---
 rtl/instr_fetch_unit.sv | 86 ++++++++
 tb/tb_instr_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time over a req/valid handshake,
// presents it with its decoded fields and picks the next PC from the CU's PCSrc.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            stall,
    output logic [XLEN-1:0] imemAddr,
    output logic            imemReq,
    input  logic            imemValid,
    input  logic [XLEN-1:0] imemRdata,
    output logic [XLEN-1:0] instr,
    output logic            instrValid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic            pcMisalign
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ERROR = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] target_d;

    // Both candidates wrap modulo 2^XLEN; a misaligned target is trapped, never loaded.
    assign target_d = PCSrc ? (pc_q + ImmExt) : (pc_q + FOUR);

    // NOTE: every state register below uses <= so all of them update from the
    // pre-edge values; a blocking = here would let later lines see half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imemValid) begin
                        instr_q <= imemRdata;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (target_d[1:0] == 2'b00) begin
                            pc_q    <= target_d;
                            state_q <= FETCH;
                        end else begin
                            state_q <= ERROR;
                        end
                    end
                end
                ERROR:   state_q <= ERROR;
                default: state_q <= ERROR;
            endcase
        end
    end

    // Handshake and status outputs decode straight from the state register.
    assign imemReq    = (state_q == FETCH);
    assign instrValid = (state_q == HOLD);
    assign pcMisalign = (state_q == ERROR);

    assign imemAddr = pc_q;
    assign PC       = pc_q;
    assign PCPlus4  = pc_q + FOUR;
    assign instr    = instr_q;
    assign opcode   = instr_q[6:0];
    assign funct3   = instr_q[14:12];
    assign funct7   = instr_q[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, all checked
// against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] ImmExt;
    logic        stall;
    logic [31:0] imemAddr;
    logic        imemReq;
    logic        imemValid;
    logic [31:0] imemRdata;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7;
    logic        pcMisalign;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .ImmExt(ImmExt), .stall(stall),
        .imemAddr(imemAddr), .imemReq(imemReq), .imemValid(imemValid),
        .imemRdata(imemRdata), .instr(instr), .instrValid(instrValid), .PC(PC),
        .PCPlus4(PCPlus4), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .pcMisalign(pcMisalign)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the word currently on offer (if any), its address, and a trap flag.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_have;
    logic        m_trap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_instr = '0;
        m_have  = 1'b0;
        m_trap  = 1'b0;
    endtask

    // One clock edge of the fetch stage in terms of the spec's rules.
    task automatic model_step(input logic src, input logic [31:0] imm, input logic stl,
                              input logic iv, input logic [31:0] rd);
        logic [31:0] nxt;
        if (m_trap) return;
        if (!m_have) begin
            if (iv) begin
                m_instr = rd;
                m_have  = 1'b1;
            end
        end else if (!stl) begin
            nxt = src ? m_pc + imm : m_pc + 32'd4;
            m_have = 1'b0;
            if (nxt % 4 == 0) m_pc = nxt;
            else m_trap = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] w;
        w = m_instr;
        check({tag, ".imemReq"},    32'(imemReq),    32'(!m_have && !m_trap));
        check({tag, ".instrValid"}, 32'(instrValid), 32'(m_have));
        check({tag, ".pcMisalign"}, 32'(pcMisalign), 32'(m_trap));
        check({tag, ".PC"},         PC,              m_pc);
        check({tag, ".imemAddr"},   imemAddr,        m_pc);
        check({tag, ".PCPlus4"},    PCPlus4,         m_pc + 32'd4);
        check({tag, ".instr"},      instr,           m_instr);
        check({tag, ".opcode"},     32'(opcode),     32'(w[6:0]));
        check({tag, ".funct3"},     32'(funct3),     32'(w[14:12]));
        check({tag, ".funct7"},     32'(funct7),     32'(w[30]));
    endtask

    task automatic cycle(input string tag, input logic src, input logic [31:0] imm,
                         input logic stl, input logic iv, input logic [31:0] rd);
        PCSrc = src; ImmExt = imm; stall = stl; imemValid = iv; imemRdata = rd;
        @(posedge clk);
        model_step(src, imm, stl, iv, rd);
        @(negedge clk);
        compare_all(tag);
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, ".rst_instrValid"}, 32'(instrValid), 32'd0);
        check({tag, ".rst_PC"}, PC, RESET_PC);
        compare_all({tag, ".rst"});
        @(negedge clk);
        rst_n = 1'b1;
        compare_all({tag, ".rel"});
    endtask

    // Fetch one word at the current PC with zero-wait memory.
    task automatic fetch(input string tag, input logic [31:0] rd);
        cycle(tag, 1'b0, 32'd0, 1'b0, 1'b1, rd);
    endtask

    initial begin
        logic [31:0] addr_snap;
        logic [31:0] instr_snap;
        rst_n = 1'b0; PCSrc = 1'b0; ImmExt = '0; stall = 1'b0;
        imemValid = 1'b0; imemRdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;
        check("first_req", 32'(imemReq), 32'd1);

        // First fetch returns in the same cycle as the request.
        fetch("t1", 32'h00500093);
        check("t1.valid", 32'(instrValid), 32'd1);
        check("t1.opcode", 32'(opcode), 32'(7'b0010011));
        check("t1.pc", PC, 32'h0);
        cycle("t1.consume", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("t1.next_addr", imemAddr, 32'h4);

        // Memory answers three cycles late.
        for (int i = 0; i < 3; i++) begin
            cycle("t2.wait", 1'b0, 32'd0, 1'b0, 1'b0, $urandom);
            check("t2.req", 32'(imemReq), 32'd1);
            check("t2.addr", imemAddr, 32'h4);
            check("t2.novalid", 32'(instrValid), 32'd0);
        end
        fetch("t2.arrive", 32'h00208133);
        cycle("t2.consume", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        fetch("t3.f", $urandom); cycle("t3.c", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        fetch("t3.f", $urandom); cycle("t3.c", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("t3.pc10", PC, 32'h10);

        // Backward and forward branches.
        fetch("t3.f", $urandom);
        cycle("t3.back", 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'd0);
        check("t3.addr08", imemAddr, 32'h08);
        fetch("t3.f", $urandom);
        cycle("t3.to10", 1'b1, 32'h8, 1'b0, 1'b0, 32'd0);
        fetch("t3.f", $urandom);
        cycle("t3.fwd", 1'b1, 32'h0C, 1'b0, 1'b0, 32'd0);
        check("t3.addr1c", imemAddr, 32'h1C);

        // Stall with PCSrc toggling: only the releasing cycle's PCSrc matters.
        fetch("t4.f", 32'hDEADBEEF);
        instr_snap = instr;
        for (int i = 0; i < 4; i++) begin
            cycle("t4.stall", 1'(i % 2 == 0), 32'h40, 1'b1, 1'(i % 2), $urandom);
            check("t4.pc", PC, 32'h1C);
            check("t4.instr", instr, instr_snap);
        end
        cycle("t4.release", 1'b0, 32'h40, 1'b0, 1'b0, 32'd0);
        check("t4.pc20", PC, 32'h20);

        // Misaligned branch target traps until reset.
        fetch("t5.f", $urandom);
        cycle("t5.bad", 1'b1, 32'h6, 1'b0, 1'b0, 32'd0);
        check("t5.misalign", 32'(pcMisalign), 32'd1);
        check("t5.req", 32'(imemReq), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle("t5.stuck", 1'($urandom), $urandom, 1'b0, 1'($urandom), $urandom);
            check("t5.pc", PC, 32'h20);
        end

        // Reset mid-HOLD, then mid-FETCH, then PC wrap-around.
        async_reset("t6a");
        fetch("t6.f", $urandom);
        async_reset("t6b");
        cycle("t6.wait", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        async_reset("t6c");
        fetch("t6.f", $urandom);
        cycle("t6.neg", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
        check("t6.pcfffc", PC, 32'hFFFF_FFFC);
        check("t6.plus4wrap", PCPlus4, 32'h0);
        fetch("t6.f", $urandom);
        cycle("t6.wrap", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("t6.pc0", PC, 32'h0);

        // Random traffic; recover from traps (and occasionally at random) via reset.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] imm;
            int k;
            k = int'($urandom_range(0, 63)) - 32;
            imm = ($urandom_range(0, 49) == 0) ? 32'(k * 4 + 2) : 32'(k * 4);
            cycle("rnd", 1'($urandom), imm, 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) != 0), $urandom);
            if (m_trap || $urandom_range(0, 299) == 0) async_reset("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
